// File: rtl/vram_pixel_shifter_pkg.sv
// Shared constants and types for the VRAM pixel shifter.
//   PLANE_W     : width of one VRAM plane byte / shift register
//   PAL_ENTRIES : number of palette entries
//   PAL_W       : width of one palette entry ({G,R,B})
//   PIPE_DEPTH  : depth of the blank/sync alignment pipeline
package vram_pixel_shifter_pkg;

  localparam int PLANE_W     = 8;
  localparam int PAL_ENTRIES = 8;
  localparam int PAL_W       = 3;
  localparam int PIPE_DEPTH  = 2;
  localparam int PAL_AW      = $clog2(PAL_ENTRIES);

  typedef logic [PAL_W-1:0]      pal_entry_t;
  typedef logic [PAL_AW-1:0]     pal_addr_t;
  typedef logic [PLANE_W-1:0]    plane_t;
  typedef logic [PIPE_DEPTH-1:0] pipe_t;

  // Next value of one plane shifter on an enabled tick: a load wins over
  // the shift, and a shift moves the next pixel bit into the MSB.
  function automatic plane_t plane_next(input plane_t cur, input plane_t din,
                                        input logic load);
    return load ? din : {cur[PLANE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/vram_pixel_shifter_if.sv
// Bus bundle between the CRTC/VRAM side and the pixel shifter.
//   Inputs to the shifter : SFTCLK, SFTLODn, SBLANKn, SHSYNCn, SVSYNCn,
//                           VDATA_B/R/G, MPAGE, PAL_WE, PAL_ADDR, PAL_DATA
//   Outputs of the shifter: RGB_OUT, DE_OUT, HSYNC_OUTn, VSYNC_OUTn
// master = the side that drives video timing and data (CRTC/VRAM),
// slave  = the pixel shifter.
// There is no valid/ready handshake: SFTCLK is a one-cycle clock enable and
// every input is sampled on the CLKSYS edge where it is high (palette write
// port excepted, which is sampled on every edge).
interface vram_pixel_shifter_if;
  import vram_pixel_shifter_pkg::*;

  logic       SFTCLK;
  logic       SFTLODn;
  logic       SBLANKn;
  logic       SHSYNCn;
  logic       SVSYNCn;
  plane_t     VDATA_B;
  plane_t     VDATA_R;
  plane_t     VDATA_G;
  logic [2:0] MPAGE;
  logic       PAL_WE;
  pal_addr_t  PAL_ADDR;
  pal_entry_t PAL_DATA;
  pal_entry_t RGB_OUT;
  logic       DE_OUT;
  logic       HSYNC_OUTn;
  logic       VSYNC_OUTn;

  modport master (
    output SFTCLK, SFTLODn, SBLANKn, SHSYNCn, SVSYNCn,
    output VDATA_B, VDATA_R, VDATA_G, MPAGE,
    output PAL_WE, PAL_ADDR, PAL_DATA,
    input  RGB_OUT, DE_OUT, HSYNC_OUTn, VSYNC_OUTn
  );

  modport slave (
    input  SFTCLK, SFTLODn, SBLANKn, SHSYNCn, SVSYNCn,
    input  VDATA_B, VDATA_R, VDATA_G, MPAGE,
    input  PAL_WE, PAL_ADDR, PAL_DATA,
    output RGB_OUT, DE_OUT, HSYNC_OUTn, VSYNC_OUTn
  );

endinterface

// File: rtl/vram_pixel_shifter_palette.sv
// pixel_palette: 8 x 3-bit colour lookup table.
//   clk_i    : system clock
//   srst_ni  : synchronous active-low reset, loads the identity map
//   we_i     : write enable, honoured on any clock edge
//   waddr_i  : write address
//   wdata_i  : write data {G,R,B}
//   raddr_i  : read address (pixel index)
//   rdata_o  : combinational read data
// A write lands in the storage at the edge, so a read at that same edge
// still sees the old entry.
module pixel_palette
  import vram_pixel_shifter_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst_ni,
  input  logic       we_i,
  input  pal_addr_t  waddr_i,
  input  pal_entry_t wdata_i,
  input  pal_addr_t  raddr_i,
  output pal_entry_t rdata_o
);

  pal_entry_t pal_q [PAL_ENTRIES];
  pal_entry_t pal_d [PAL_ENTRIES];

  always_comb begin
    pal_d = pal_q;
    if (we_i) begin
      pal_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= pal_entry_t'(i);
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  assign rdata_o = pal_q[raddr_i];

endmodule

// File: rtl/vram_pixel_shifter.sv
// vram_pixel_shifter: serialises three VRAM plane bytes into 3-bit pixels,
// maps them through a palette and aligns blank/sync to the pixel stream.
//   CLKSYS  : system clock, everything on the rising edge
//   SRESETn : synchronous active-low reset
//   bus     : slave side of vram_pixel_shifter_if (pixel clock enable,
//             load strobe, blank/syncs, plane bytes, plane mask, palette
//             write port, RGB/DE/HSYNC/VSYNC outputs)
// Timing: a byte loaded at enabled tick n has its MSB registered on RGB_OUT
// at tick n+1; the blank/sync pipeline is two enabled ticks deep so that
// DE_OUT and the syncs leave on the same tick as that pixel.
module vram_pixel_shifter
  import vram_pixel_shifter_pkg::*;
(
  input  logic                   CLKSYS,
  input  logic                   SRESETn,
  vram_pixel_shifter_if.slave    bus
);

  plane_t     sh_b_q, sh_b_d;
  plane_t     sh_r_q, sh_r_d;
  plane_t     sh_g_q, sh_g_d;
  pipe_t      blank_q, blank_d;
  pipe_t      hsync_q, hsync_d;
  pipe_t      vsync_q, vsync_d;
  pal_entry_t rgb_q, rgb_d;
  pal_addr_t  pix_idx;
  pal_entry_t pal_rdata;
  logic       tick;
  logic       load;

  assign tick = bus.SFTCLK;
  assign load = ~bus.SFTLODn;

  // Index uses the shifter MSBs before this tick's update; the mask is
  // applied live so a mid-byte MPAGE change takes effect on the next pixel.
  assign pix_idx = pal_addr_t'({sh_g_q[PLANE_W-1], sh_r_q[PLANE_W-1],
                                sh_b_q[PLANE_W-1]} & ~bus.MPAGE);

  pixel_palette u_palette (
    .clk_i   (CLKSYS),
    .srst_ni (SRESETn),
    .we_i    (bus.PAL_WE),
    .waddr_i (bus.PAL_ADDR),
    .wdata_i (bus.PAL_DATA),
    .raddr_i (pix_idx),
    .rdata_o (pal_rdata)
  );

  always_comb begin
    sh_b_d  = sh_b_q;
    sh_r_d  = sh_r_q;
    sh_g_d  = sh_g_q;
    blank_d = blank_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick) begin
      sh_b_d  = plane_next(sh_b_q, bus.VDATA_B, load);
      sh_r_d  = plane_next(sh_r_q, bus.VDATA_R, load);
      sh_g_d  = plane_next(sh_g_q, bus.VDATA_G, load);
      blank_d = {blank_q[PIPE_DEPTH-2:0], bus.SBLANKn};
      hsync_d = {hsync_q[PIPE_DEPTH-2:0], bus.SHSYNCn};
      vsync_d = {vsync_q[PIPE_DEPTH-2:0], bus.SVSYNCn};
      // Gate with the blank bit that moves into the last stage this tick,
      // i.e. the one DE_OUT will show alongside this pixel.
      rgb_d   = blank_q[PIPE_DEPTH-2] ? pal_rdata : '0;
    end
  end

  always_ff @(posedge CLKSYS) begin
    if (!SRESETn) begin
      sh_b_q  <= '0;
      sh_r_q  <= '0;
      sh_g_q  <= '0;
      blank_q <= '0;
      hsync_q <= '1;
      vsync_q <= '1;
      rgb_q   <= '0;
    end else begin
      sh_b_q  <= sh_b_d;
      sh_r_q  <= sh_r_d;
      sh_g_q  <= sh_g_d;
      blank_q <= blank_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.RGB_OUT    = rgb_q;
  assign bus.DE_OUT     = blank_q[PIPE_DEPTH-1];
  assign bus.HSYNC_OUTn = hsync_q[PIPE_DEPTH-1];
  assign bus.VSYNC_OUTn = vsync_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vram_pixel_shifter.sv
// Directed bench for vram_pixel_shifter. Expected values are hand-derived
// from the pixel mapping {G,R,B} = {SH_G[7],SH_R[7],SH_B[7]} & ~MPAGE.
module tb_vram_pixel_shifter;
  import vram_pixel_shifter_pkg::*;

  logic clk = 1'b0;
  logic srst_n;
  int   checks = 0;
  int   errors = 0;

  vram_pixel_shifter_if bus ();

  vram_pixel_shifter dut (
    .CLKSYS  (clk),
    .SRESETn (srst_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Packs {DE, HSYNCn, VSYNCn, RGB} into one comparison.
  task automatic check_out(input string tag, input logic de, input logic hs,
                           input logic vs, input logic [2:0] rgb);
    check(tag, {2'b00, bus.DE_OUT, bus.HSYNC_OUTn, bus.VSYNC_OUTn, bus.RGB_OUT},
          {2'b00, de, hs, vs, rgb});
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic en);
    bus.SFTCLK = en;
    @(posedge clk);
    #1;
    bus.SFTCLK = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic [7:0] r,
                           input logic [7:0] g);
    bus.SFTLODn = 1'b0;
    bus.VDATA_B = b;
    bus.VDATA_R = r;
    bus.VDATA_G = g;
    step(1'b1);
    bus.SFTLODn = 1'b1;
  endtask

  // Eight shift ticks; seq holds the expected pixels, first one in the MSBs.
  task automatic shift_check(input string tag, input logic [23:0] seq);
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
      check_out($sformatf("%s_px%0d", tag, k), 1'b1, 1'b1, 1'b1, seq[23-3*k -: 3]);
    end
  endtask

  task automatic pal_write(input logic [2:0] addr, input logic [2:0] data);
    bus.PAL_WE   = 1'b1;
    bus.PAL_ADDR = addr;
    bus.PAL_DATA = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.SFTCLK   = 1'b0;
    bus.SFTLODn  = 1'b1;
    bus.SBLANKn  = 1'b1;
    bus.SHSYNCn  = 1'b1;
    bus.SVSYNCn  = 1'b1;
    bus.VDATA_B  = '0;
    bus.VDATA_R  = '0;
    bus.VDATA_G  = '0;
    bus.MPAGE    = 3'b000;
    bus.PAL_WE   = 1'b0;
    bus.PAL_ADDR = '0;
    bus.PAL_DATA = '0;
    srst_n       = 1'b0;

    // Reset with a tick, a load and a palette write all pending.
    bus.SFTCLK  = 1'b1;
    bus.SFTLODn = 1'b0;
    bus.VDATA_B = 8'hFF;
    bus.VDATA_R = 8'hFF;
    bus.VDATA_G = 8'hFF;
    pal_write(3'd0, 3'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b1, 1'b1, 3'd0);
    srst_n      = 1'b1;
    bus.SFTCLK  = 1'b0;
    bus.SFTLODn = 1'b1;
    bus.PAL_WE  = 1'b0;

    // Blue byte, one enabled tick every two cycles.
    load_byte(8'hFF, 8'h00, 8'h00);
    check_out("t1_load", 1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
      check_out($sformatf("t1_px%0d", k), 1'b1, 1'b1, 1'b1, 3'd1);
      step(1'b0);
      check_out($sformatf("t1_hold%0d", k), 1'b1, 1'b1, 1'b1, 3'd1);
    end
    step(1'b1);
    check_out("t1_empty", 1'b1, 1'b1, 1'b1, 3'd0);

    // Mixed planes, identity palette: bits 7..0 give 5,6,5,6,1,2,1,2.
    load_byte(8'hAA, 8'h55, 8'hF0);
    check_out("t2_load", 1'b1, 1'b1, 1'b1, 3'd0);
    shift_check("t2", {3'd5, 3'd6, 3'd5, 3'd6, 3'd1, 3'd2, 3'd1, 3'd2});

    // PAL[7]=2, G masked -> index 3; then unmasked -> index 7.
    pal_write(3'd7, 3'd2);
    step(1'b0);
    bus.PAL_WE = 1'b0;
    bus.MPAGE  = 3'b100;
    load_byte(8'hFF, 8'hFF, 8'hFF);
    shift_check("t3a", {8{3'd3}});
    bus.MPAGE = 3'b000;
    load_byte(8'hFF, 8'hFF, 8'hFF);
    check_out("t3b_load", 1'b1, 1'b1, 1'b1, 3'd0);
    shift_check("t3b", {8{3'd2}});

    // Mask changed mid-byte takes effect on the very next pixel.
    load_byte(8'hFF, 8'hFF, 8'hFF);
    step(1'b1);
    check_out("t3c_m0", 1'b1, 1'b1, 1'b1, 3'd2);
    bus.MPAGE = 3'b001;
    step(1'b1);
    check_out("t3c_m1", 1'b1, 1'b1, 1'b1, 3'd6);
    bus.MPAGE = 3'b111;
    step(1'b1);
    check_out("t3c_m7", 1'b1, 1'b1, 1'b1, 3'd0);
    bus.MPAGE = 3'b000;

    // Blank at the load tick suppresses that byte's first pixel.
    bus.SBLANKn = 1'b0;
    load_byte(8'hFF, 8'hFF, 8'hFF);
    bus.SBLANKn = 1'b1;
    check_out("t4_leftover", 1'b1, 1'b1, 1'b1, 3'd2);
    step(1'b1);
    check_out("t4_blank", 1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b1);
    check_out("t4_unblank", 1'b1, 1'b1, 1'b1, 3'd2);

    // 64-tick HSYNC pulse comes out low after ticks 1..64.
    for (int i = 0; i < 70; i++) begin
      bus.SHSYNCn = (i < 64) ? 1'b0 : 1'b1;
      step(1'b1);
      check($sformatf("t4_hs%0d", i), {7'd0, bus.HSYNC_OUTn},
            {7'd0, ((i >= 1) && (i <= 64)) ? 1'b0 : 1'b1});
    end

    // One-tick VSYNC pulse, two-stage delay.
    bus.SVSYNCn = 1'b0;
    step(1'b1);
    check("t4_vs0", {7'd0, bus.VSYNC_OUTn}, 8'd1);
    bus.SVSYNCn = 1'b1;
    step(1'b1);
    check("t4_vs1", {7'd0, bus.VSYNC_OUTn}, 8'd0);
    step(1'b1);
    check("t4_vs2", {7'd0, bus.VSYNC_OUTn}, 8'd1);

    // Reload after four pixels; palette write with and without a tick.
    load_byte(8'hFF, 8'h00, 8'h00);
    check_out("t5_load1", 1'b1, 1'b1, 1'b1, 3'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check_out($sformatf("t5_a%0d", k), 1'b1, 1'b1, 1'b1, 3'd1);
    end
    load_byte(8'h00, 8'hFF, 8'h00);
    check_out("t5_load2", 1'b1, 1'b1, 1'b1, 3'd1);
    step(1'b1);
    check_out("t5_new", 1'b1, 1'b1, 1'b1, 3'd2);
    pal_write(3'd2, 3'd5);
    step(1'b0);
    bus.PAL_WE = 1'b0;
    check_out("t5_wr_hold", 1'b1, 1'b1, 1'b1, 3'd2);
    step(1'b1);
    check_out("t5_wr_seen", 1'b1, 1'b1, 1'b1, 3'd5);
    pal_write(3'd2, 3'd6);
    step(1'b1);
    bus.PAL_WE = 1'b0;
    check_out("t5_wr_same", 1'b1, 1'b1, 1'b1, 3'd5);
    step(1'b1);
    check_out("t5_wr_next", 1'b1, 1'b1, 1'b1, 3'd6);

    // Reset mid-byte with tick, load and palette write pending.
    load_byte(8'hFF, 8'hFF, 8'hFF);
    check_out("t6_leftover", 1'b1, 1'b1, 1'b1, 3'd6);
    step(1'b1);
    check_out("t6_px0", 1'b1, 1'b1, 1'b1, 3'd2);
    srst_n      = 1'b0;
    bus.SFTLODn = 1'b0;
    bus.SHSYNCn = 1'b0;
    bus.SVSYNCn = 1'b0;
    pal_write(3'd0, 3'd7);
    step(1'b1);
    check_out("t6_reset", 1'b0, 1'b1, 1'b1, 3'd0);
    srst_n      = 1'b1;
    bus.SFTLODn = 1'b1;
    bus.SHSYNCn = 1'b1;
    bus.SVSYNCn = 1'b1;
    bus.PAL_WE  = 1'b0;
    step(1'b1);
    check_out("t6_post0", 1'b0, 1'b1, 1'b1, 3'd0);
    step(1'b1);
    check_out("t6_post1", 1'b1, 1'b1, 1'b1, 3'd0);
    load_byte(8'hFF, 8'hFF, 8'hFF);
    check_out("t6_load", 1'b1, 1'b1, 1'b1, 3'd0);
    shift_check("t6", {8{3'd7}});

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
